// File: rtl/data_mem_responder_pkg.sv
// mem_resp_pkg: shared types and constants for the data memory responder.
//   state_e      - responder FSM states (IDLE, WAIT, DONE)
//   CNT_W        - width of the wait-state down-counter
//   DATA_W_DEF   - default data width (64)
//   idx_width()  - doubleword index width for a given storage depth
package mem_resp_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    // Index width into the doubleword array; a depth of 1 still needs one bit.
    function automatic int idx_width(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// data_mem_responder_if: request/response bundle between the datapath
// (master) and the memory responder (slave).
//   mem_read, mem_write : requests, held by the master until ready
//   addr                : 64-bit byte address
//   wdata / rdata       : write data / registered read data
//   ready               : one-cycle completion pulse
//   busy                : transaction in flight
//   err                 : access error, qualified by ready
interface data_mem_responder_if #(
    parameter int DATA_W = mem_resp_pkg::DATA_W_DEF
);
    import mem_resp_pkg::*;

    logic              mem_read;
    logic              mem_write;
    logic [63:0]       addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              busy;
    logic              err;

    modport master (
        output mem_read, mem_write, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  mem_read, mem_write, addr, wdata,
        output rdata, ready, busy, err
    );

endinterface

// File: rtl/data_mem_responder_dmem_array.sv
// dmem_array: DEPTH x DATA_W doubleword storage.
//   clk    - rising-edge clock
//   rst_n  - async active-low reset (clears rdata only; contents are not reset)
//   we     - write enable, writes wdata to mem[idx]
//   re     - read enable, captures mem[idx] into rdata
//   idx    - doubleword index
//   wdata  - write data
//   rdata  - registered read data, holds between reads
module dmem_array #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 64,
    parameter int IDX_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [IDX_W-1:0]  idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    import mem_resp_pkg::*;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[idx];
        end
    end

    // Storage has no reset, so a clock edge while reset is held must not
    // commit a write that the (reset) controller could still be decoding.
    always_ff @(posedge clk) begin
        if (we && rst_n) begin
            mem_q[idx] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side responder with a fixed number of wait
// states, for the multicycle datapath's data/instruction port.
//   clock  - rising-edge clock
//   reset  - async active-low reset
//   bus    - data_mem_responder_if.slave (mem_read, mem_write, addr, wdata,
//            rdata, ready, busy, err)
// Parameters: DEPTH (doublewords, power of two), WAIT_CYCLES (0..15), DATA_W.
// Build option: define MEMRESP_ERR_EN to flag misaligned / out-of-range
// addresses (err with ready, access suppressed). Without it err is 0 and the
// index wraps modulo DEPTH.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for mem_read/mem_write, request latched on accept
// WAIT  | counting down wait states on the latched request
// DONE  | access committed, ready (and err) high for this cycle
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter int DATA_W      = mem_resp_pkg::DATA_W_DEF
) (
    input  logic                 clock,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    import mem_resp_pkg::*;

    localparam int              IDX_W     = idx_width(DEPTH);
    localparam bit              ZERO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q,   cnt_d;
    logic [IDX_W-1:0]    idx_q,   idx_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                wr_q,    wr_d;
    logic                errp_q,  errp_d;
    logic                ready_q, ready_d;
    logic                busy_q,  busy_d;
    logic                err_q,   err_d;

    logic                req;
    logic                in_err;
    logic                go_done;
    logic                mem_we;
    logic                mem_re;
    logic [DATA_W-1:0]   rdata;
    logic [IDX_W-1:0]    in_idx;

    assign req    = bus.mem_read | bus.mem_write;
    assign in_idx = bus.addr[3 +: IDX_W];

`ifdef MEMRESP_ERR_EN
    assign in_err = (bus.addr[2:0] != 3'd0) || (|bus.addr[63:3+IDX_W]);
`else
    logic unused_ok;
    assign in_err    = 1'b0;
    assign unused_ok = ^{bus.addr[2:0], bus.addr[63:3+IDX_W], err_q};
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        errp_d  = errp_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        go_done = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    idx_d   = in_idx;
                    wdata_d = bus.wdata;
                    // Write wins when both requests are raised together.
                    wr_d    = bus.mem_write;
                    errp_d  = in_err;
                    busy_d  = 1'b1;
                    if (ZERO_WAIT) begin
                        state_d = DONE;
                        go_done = 1'b1;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    go_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        if (go_done) begin
            ready_d = 1'b1;
            err_d   = errp_d;
        end
    end

    // The access uses the _d view of the latched request so that the
    // zero-wait path (accept and complete on the same edge) sees live inputs.
    assign mem_we = go_done &  wr_d & ~errp_d;
    assign mem_re = go_done & ~wr_d & ~errp_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            errp_q  <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            errp_q  <= errp_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
        end
    end

    dmem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk   (clock),
        .rst_n (reset),
        .we    (mem_we),
        .re    (mem_re),
        .idx   (idx_d),
        .wdata (wdata_d),
        .rdata (rdata)
    );

    assign bus.rdata = rdata;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
`ifdef MEMRESP_ERR_EN
    assign bus.err   = err_q;
`else
    assign bus.err   = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: main instance with WAIT_CYCLES=2 checked
// every cycle against a transaction-level model, plus a WAIT_CYCLES=0
// instance checked with literal expectations.
module tb_data_mem_responder;

    localparam int W     = 2;
    localparam int DEPTH = 256;
`ifdef MEMRESP_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    localparam logic [63:0] D_DEAD = 64'hDEADBEEF_CAFEF00D;
    localparam logic [63:0] D_A    = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_B    = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D_X1   = 64'h0101_0101_0101_0101;
    localparam logic [63:0] D_X2   = 64'h0202_0202_0202_0202;
    localparam logic [63:0] D_Z    = 64'hA5A5_5A5A_0F0F_F0F0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if bus  ();
    data_mem_responder_if bus0 ();

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(W), .DATA_W(64)) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    data_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .DATA_W(64)) dut0 (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model of the W=2 instance ----------
    // Each accepted request completes W+1 cycles after its request cycle;
    // the responder is free again the cycle after completion.
    logic [63:0] mmem   [DEPTH];
    bit          mknown [DEPTH];
    longint      cyc       = 0;
    longint      free_from = 0;
    bit          have      = 1'b0;
    longint      t_acc     = 0;
    longint      t_done    = 0;
    bit          t_wr      = 1'b0;
    bit          t_err     = 1'b0;
    logic [63:0] t_addr    = '0;
    logic [63:0] t_wdata   = '0;
    logic        e_ready   = 1'b0;
    logic        e_busy    = 1'b0;
    logic        e_err     = 1'b0;
    logic [63:0] e_rdata   = '0;
    bit          e_rknown  = 1'b1;

    function automatic bit addr_err(input logic [63:0] a);
        return ERR_EN && ((a % 8) != 0 || (a / (8 * DEPTH)) != 0);
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        longint      c;
        bit          hv, twr, terr, rdy;
        longint      ta, td;
        logic [63:0] taddr, twd;
        int          mi;
        if (!rst_n) begin
            have      <= 1'b0;
            free_from <= 0;
            e_ready   <= 1'b0;
            e_busy    <= 1'b0;
            e_err     <= 1'b0;
            e_rdata   <= '0;
            e_rknown  <= 1'b1;
        end else begin
            c = cyc + 1;
            hv = have; ta = t_acc; td = t_done; twr = t_wr; terr = t_err;
            taddr = t_addr; twd = t_wdata;
            if ((c - 1) >= free_from && (bus.mem_read || bus.mem_write)) begin
                hv    = 1'b1;
                ta    = c - 1;
                td    = ta + W + 1;
                twr   = bus.mem_write;
                taddr = bus.addr;
                twd   = bus.wdata;
                terr  = addr_err(bus.addr);
                free_from <= td + 1;
            end
            rdy = hv && (c == td);
            e_ready <= rdy;
            e_busy  <= hv && (c > ta) && (c <= td);
            e_err   <= rdy && terr;
            if (rdy && !terr) begin
                mi = int'(taddr / 8) % DEPTH;
                if (twr) begin
                    mmem[mi]   <= twd;
                    mknown[mi] <= 1'b1;
                end else begin
                    e_rdata  <= mmem[mi];
                    e_rknown <= mknown[mi];
                end
            end
            cyc     <= c;
            have    <= hv;
            t_acc   <= ta;
            t_done  <= td;
            t_wr    <= twr;
            t_err   <= terr;
            t_addr  <= taddr;
            t_wdata <= twd;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", {63'd0, bus.ready}, 64'd0);
            chk("rst_busy",  {63'd0, bus.busy},  64'd0);
            chk("rst_err",   {63'd0, bus.err},   64'd0);
            chk("rst_rdata", bus.rdata,          64'd0);
        end else begin
            chk("cyc_ready", {63'd0, bus.ready}, {63'd0, e_ready});
            chk("cyc_busy",  {63'd0, bus.busy},  {63'd0, e_busy});
            chk("cyc_err",   {63'd0, bus.err},   {63'd0, e_err});
            if (e_rknown) chk("cyc_rdata", bus.rdata, e_rdata);
        end
    end

    // ---------------- directed stimulus ------------------------------------
    task automatic txn(input logic rd, input logic wr, input logic [63:0] a,
                       input logic [63:0] d, output int lat,
                       output logic [63:0] rv, output logic ev);
        lat = -1; rv = '0; ev = 1'b0;
        @(posedge clk); #1;
        bus.mem_read = rd; bus.mem_write = wr; bus.addr = a; bus.wdata = d;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.ready) begin
                lat = n; rv = bus.rdata; ev = bus.err;
                break;
            end
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL txn_timeout: no ready for addr %h", a);
        end
    endtask

    task automatic w0_txn(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [63:0] d, output logic [63:0] rv);
        @(posedge clk); #1;
        bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.wdata = d;
        @(negedge clk);
        chk("w0_req_ready", {63'd0, bus0.ready}, 64'd0);
        chk("w0_req_busy",  {63'd0, bus0.busy},  64'd0);
        @(negedge clk);
        chk("w0_ready", {63'd0, bus0.ready}, 64'd1);
        chk("w0_busy",  {63'd0, bus0.busy},  64'd1);
        rv = bus0.rdata;
        bus0.mem_read = 1'b0; bus0.mem_write = 1'b0;
        @(negedge clk);
        chk("w0_after_ready", {63'd0, bus0.ready}, 64'd0);
        chk("w0_after_busy",  {63'd0, bus0.busy},  64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        int          gap;
        int          pulses;
        logic [63:0] rv;
        logic        ev;

        bus.mem_read  = 1'b0; bus.mem_write  = 1'b0; bus.addr  = '0; bus.wdata  = '0;
        bus0.mem_read = 1'b0; bus0.mem_write = 1'b0; bus0.addr = '0; bus0.wdata = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("init_rdata", bus.rdata, 64'd0);
        chk("init_busy",  {63'd0, bus.busy}, 64'd0);

        // write/read round trip
        txn(1'b0, 1'b1, 64'h40, D_DEAD, lat, rv, ev);
        chk("wr_latency", 64'(lat), 64'd3);
        txn(1'b1, 1'b0, 64'h40, '0, lat, rv, ev);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_data", rv, D_DEAD);

        // reset in the middle of a write's wait states
        txn(1'b0, 1'b1, 64'h10, D_A, lat, rv, ev);
        @(posedge clk); #1;
        bus.mem_write = 1'b1; bus.addr = 64'h10; bus.wdata = D_B;
        @(posedge clk); #3;
        rst_n = 1'b0;
        bus.mem_write = 1'b0;
        @(negedge clk);
        chk("midrst_busy",  {63'd0, bus.busy},  64'd0);
        chk("midrst_rdata", bus.rdata, 64'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        pulses = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (bus.ready) pulses++;
        end
        chk("midrst_no_ready", 64'(pulses), 64'd0);
        txn(1'b1, 1'b0, 64'h10, '0, lat, rv, ev);
        chk("midrst_prior_data", rv, D_A);

        // simultaneous read+write: write wins, rdata kept
        txn(1'b1, 1'b1, 64'h18, 64'h1234, lat, rv, ev);
        chk("simul_rdata_kept", rv, D_A);
        txn(1'b1, 1'b0, 64'h18, '0, lat, rv, ev);
        chk("simul_readback", rv, 64'h1234);

        // request held one cycle past ready is re-accepted; inputs changed
        // during the second transaction's wait states are ignored
        @(posedge clk); #1;
        bus.mem_read = 1'b1; bus.addr = 64'h40;
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.ready) begin lat = n; break; end
        end
        chk("hold_first_latency", 64'(lat), 64'd3);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b1;
        bus.addr = 64'h18; bus.wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        gap = -1;
        for (int n = 2; n < 40; n++) begin
            @(negedge clk);
            if (bus.ready) begin gap = n; rv = bus.rdata; break; end
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        chk("hold_second_gap", 64'(gap), 64'(W + 2));
        chk("hold_second_data", rv, D_DEAD);
        txn(1'b1, 1'b0, 64'h18, '0, lat, rv, ev);
        chk("hold_no_write", rv, 64'h1234);

        // index wrap vs. error flagging
        txn(1'b0, 1'b1, 64'h8, D_X1, lat, rv, ev);
        txn(1'b0, 1'b1, 64'h808, D_X2, lat, rv, ev);
        chk("wrap_wr_err", {63'd0, ev}, {63'd0, ERR_EN});
        chk("wrap_wr_latency", 64'(lat), 64'd3);
        txn(1'b1, 1'b0, 64'h8, '0, lat, rv, ev);
        chk("wrap_alias_data", rv, ERR_EN ? D_X1 : D_X2);
        txn(1'b1, 1'b0, 64'h44, '0, lat, rv, ev);
        chk("misalign_err", {63'd0, ev}, {63'd0, ERR_EN});
        chk("misalign_rdata", rv, ERR_EN ? D_X1 : D_DEAD);

        // zero-wait instance
        w0_txn(1'b0, 1'b1, 64'h8, D_Z, rv);
        w0_txn(1'b1, 1'b0, 64'h8, '0, rv);
        chk("w0_read_data", rv, D_Z);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
